// File: rtl/obi_pkg.sv
// obi_pkg: shared types and constants for the OBI word-copy DMA engine.
package obi_pkg;

    // Engine FSM states.
    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } dma_state_e;

    // Every transfer is a full 32-bit word.
    localparam logic [3:0]  OBI_BE_FULL    = 4'hF;
    localparam logic [31:0] OBI_WORD_BYTES = 32'd4;

endpackage

// File: rtl/obi_if.sv
// obi_if: request/grant/rvalid OBI subset used between the DMA initiator
// and the memory crossbar / SRAM data port.
interface obi_if;

    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/obi_dma_range_chk.sv
// obi_dma_range_chk: combinational check that the word run
// [base, base + 4*len) lies inside [RANGE_BASE, RANGE_END). The sum is
// formed in 33 bits so a run that wraps past 2^32 is reported as out of range.
module obi_dma_range_chk #(
    parameter int          LEN_W      = 16,
    parameter logic [31:0] RANGE_BASE = 32'h8000_0000,
    parameter logic [31:0] RANGE_END  = 32'h8000_C000
) (
    input  logic [31:0]      base_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             in_range_o
);

    logic [32:0] start_ext;
    logic [32:0] end_ext;
    logic        unused_base_lsbs;

    // Byte offsets [1:0] carry no meaning for word transfers.
    assign unused_base_lsbs = ^base_i[1:0];

    assign start_ext  = {1'b0, base_i[31:2], 2'b00};
    assign end_ext    = start_ext + {{(33 - LEN_W - 2){1'b0}}, len_i, 2'b00};
    assign in_range_o = (start_ext >= {1'b0, RANGE_BASE}) &&
                        (end_ext   <= {1'b0, RANGE_END});

endmodule

// File: rtl/obi_dma_copy.sv
// obi_dma_copy: single-channel word-copy DMA acting as an OBI initiator.
// One read then one write per word, one transaction outstanding at a time.
// Optional feature macro: OBI_DMA_RANGE_CHECK_EN enables the source/destination
// address range check at start; without it err_o stays 0.
module obi_dma_copy
    import obi_pkg::*;
#(
    parameter int          LEN_W      = 16,
    parameter logic [31:0] RANGE_BASE = 32'h8000_0000,
    parameter logic [31:0] RANGE_END  = 32'h8000_C000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] words_done_o,
    obi_if.master            obi
);

    dma_state_e       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] words_q, words_d;
    logic [31:0]      buf_q, buf_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] words_inc;
    logic             range_bad;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^{src_addr_i[1:0], dst_addr_i[1:0]};
    assign words_inc        = words_q + LEN_W'(1);

`ifdef OBI_DMA_RANGE_CHECK_EN
    logic src_in_range;
    logic dst_in_range;

    obi_dma_range_chk #(
        .LEN_W      (LEN_W),
        .RANGE_BASE (RANGE_BASE),
        .RANGE_END  (RANGE_END)
    ) u_src_chk (
        .base_i     (src_addr_i),
        .len_i      (len_i),
        .in_range_o (src_in_range)
    );

    obi_dma_range_chk #(
        .LEN_W      (LEN_W),
        .RANGE_BASE (RANGE_BASE),
        .RANGE_END  (RANGE_END)
    ) u_dst_chk (
        .base_i     (dst_addr_i),
        .len_i      (len_i),
        .in_range_o (dst_in_range)
    );

    assign range_bad = !(src_in_range && dst_in_range);
`else
    logic unused_range_cfg;

    assign unused_range_cfg = ^{RANGE_BASE, RANGE_END};
    assign range_bad        = 1'b0;
`endif

    // State and datapath registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            words_q <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            words_q <= words_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every variable gets a hold default before the case so no
        // branch can leave one unassigned and infer a latch.
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        words_d = words_q;
        buf_d   = buf_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d   = {src_addr_i[31:2], 2'b00};
                    dst_d   = {dst_addr_i[31:2], 2'b00};
                    len_d   = len_i;
                    words_d = '0;
                    err_d   = 1'b0;
                    if (len_i == '0) begin
                        state_d = DONE;
                    end else if (range_bad) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (obi.gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (obi.rvalid) begin
                    buf_d   = obi.rdata;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (obi.gnt) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (obi.rvalid) begin
                    src_d   = src_q + OBI_WORD_BYTES;
                    dst_d   = dst_q + OBI_WORD_BYTES;
                    words_d = words_inc;
                    state_d = (words_inc == len_q) ? DONE : RD_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state; request fields are held
    // registers, so they cannot move while a request waits for grant.
    always_comb begin
        busy_o       = (state_q != IDLE);
        done_o       = (state_q == DONE);
        err_o        = err_q;
        words_done_o = words_q;
        obi.req      = (state_q == RD_REQ) || (state_q == WR_REQ);
        obi.we       = (state_q == WR_REQ);
        obi.addr     = (state_q == WR_REQ) ? dst_q : src_q;
        obi.wdata    = buf_q;
        obi.be       = OBI_BE_FULL;
    end

endmodule

// File: tb/tb_obi_dma_copy.sv
// tb_obi_dma_copy: directed self-checking bench for obi_dma_copy. The bench
// acts as the OBI responder (grant, rvalid one cycle after grant).
module tb_obi_dma_copy;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [31:0]      src_addr_i;
    logic [31:0]      dst_addr_i;
    logic [LEN_W-1:0] len_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [LEN_W-1:0] words_done_o;

    obi_if obi ();

    obi_dma_copy #(.LEN_W(LEN_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .src_addr_i   (src_addr_i),
        .dst_addr_i   (dst_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .words_done_o (words_done_o),
        .obi          (obi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Results of the last run_copy call.
    int          n_tx;
    logic        tx_we    [32];
    logic [31:0] tx_addr  [32];
    logic [31:0] tx_wdata [32];
    int          done_at;
    int          stall_seen;
    int          stable_bad;
    logic        first_req;
    logic        any_req;
    logic        busy_at_done;
    logic        busy_after;

    // Responder memory contents: a fixed pattern derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Start a copy and act as responder until one cycle after done_o.
    // stall_wr: grant-low cycles applied to the first write request.
    // mid_start_at: cycle index at which a second start pulse is driven (0 = none).
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [LEN_W-1:0] len, input int stall_wr,
                            input int mid_start_at);
        int          cyc;
        int          stall_left;
        logic        pend;
        logic [31:0] pend_data;
        logic        held_v;
        logic        held_we;
        logic [31:0] held_addr;
        logic [31:0] held_wdata;
        logic        s_req, s_gnt, s_we;
        logic [31:0] s_addr, s_wdata;
        n_tx = 0; done_at = 0; stall_seen = 0; stable_bad = 0;
        first_req = 1'b0; any_req = 1'b0; busy_at_done = 1'b0; busy_after = 1'b1;
        pend = 1'b0; pend_data = '0; held_v = 1'b0; stall_left = stall_wr;
        held_we = 1'b0; held_addr = '0; held_wdata = '0;
        @(negedge clk);
        src_addr_i = src; dst_addr_i = dst; len_i = len; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            if (cyc == 1) first_req = obi.req;
            if (obi.req) any_req = 1'b1;
            if (done_o && done_at == 0) begin
                done_at = cyc;
                busy_at_done = busy_o;
            end
            if (done_at != 0 && cyc == done_at + 1) begin
                busy_after = busy_o;
                break;
            end
            obi.rvalid = pend;
            obi.rdata  = pend_data;
            obi.gnt    = obi.req && !(obi.we && stall_left > 0);
            if (obi.req && !obi.gnt) begin
                stall_left--;
                stall_seen++;
                if (held_v) begin
                    if (obi.addr !== held_addr || obi.we !== held_we ||
                        obi.wdata !== held_wdata) stable_bad++;
                end else begin
                    held_v = 1'b1; held_we = obi.we;
                    held_addr = obi.addr; held_wdata = obi.wdata;
                end
            end else begin
                held_v = 1'b0;
            end
            if (cyc == mid_start_at) begin
                start_i = 1'b1; len_i = 5; src_addr_i = 32'h8000_8000;
            end else begin
                start_i = 1'b0;
            end
            s_req = obi.req; s_gnt = obi.gnt; s_we = obi.we;
            s_addr = obi.addr; s_wdata = obi.wdata;
            @(posedge clk); #1;
            pend = 1'b0;
            if (s_req && s_gnt) begin
                if (n_tx < 32) begin
                    tx_we[n_tx] = s_we; tx_addr[n_tx] = s_addr; tx_wdata[n_tx] = s_wdata;
                end
                n_tx++;
                pend = 1'b1;
                pend_data = s_we ? 32'h0 : mem_word(s_addr);
            end
            cyc++;
        end
        start_i = 1'b0; obi.gnt = 1'b0; obi.rvalid = 1'b0;
        checks++;
        if (done_at == 0) begin
            errors++;
            $display("FAIL copy_timeout: done_o not seen within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; src_addr_i = '0; dst_addr_i = '0; len_i = '0;
        obi.gnt = 1'b0; obi.rvalid = 1'b0; obi.rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_o); end
        checks++; if (words_done_o !== '0) begin errors++; $display("FAIL reset_words: got %0d expected 0", words_done_o); end
        checks++; if (obi.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", obi.req); end
        checks++; if (obi.be !== 4'hF) begin errors++; $display("FAIL reset_be: got %h expected f", obi.be); end
        rst_i = 1'b0;
    endtask

    task automatic test_basic_copy();
        logic        exp_we;
        logic [31:0] exp_addr;
        run_copy(32'h8000_0000, 32'h8000_1000, 16'd3, 0, 0);
        checks++; if (n_tx !== 6) begin errors++; $display("FAIL basic_tx_count: got %0d expected 6", n_tx); end
        for (int i = 0; i < 6 && i < n_tx; i++) begin
            exp_we   = (i % 2) == 1;
            exp_addr = exp_we ? 32'h8000_1000 + 32'(4 * (i / 2)) : 32'h8000_0000 + 32'(4 * (i / 2));
            checks++;
            if (tx_we[i] !== exp_we || tx_addr[i] !== exp_addr) begin
                errors++;
                $display("FAIL basic_tx%0d: got we=%b addr=%h expected we=%b addr=%h",
                         i, tx_we[i], tx_addr[i], exp_we, exp_addr);
            end
            if (exp_we) begin
                checks++;
                if (tx_wdata[i] !== mem_word(32'h8000_0000 + 32'(4 * (i / 2)))) begin
                    errors++;
                    $display("FAIL basic_wdata%0d: got %h expected %h", i, tx_wdata[i],
                             mem_word(32'h8000_0000 + 32'(4 * (i / 2))));
                end
            end
        end
        checks++; if (done_at !== 13) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 13", done_at); end
        checks++; if (words_done_o !== 16'd3) begin errors++; $display("FAIL basic_words: got %0d expected 3", words_done_o); end
        checks++; if (first_req !== 1'b1) begin errors++; $display("FAIL basic_first_req: got %b expected 1", first_req); end
        checks++; if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin
            errors++; $display("FAIL basic_busy: got done=%b after=%b expected 1/0", busy_at_done, busy_after);
        end
    endtask

    task automatic test_len_zero();
        run_copy(32'h8000_0000, 32'h8000_1000, 16'd0, 0, 0);
        checks++; if (done_at !== 1) begin errors++; $display("FAIL len0_done_cycle: got %0d expected 1", done_at); end
        checks++; if (any_req !== 1'b0 || n_tx !== 0) begin
            errors++; $display("FAIL len0_traffic: got req_seen=%b tx=%0d expected 0/0", any_req, n_tx);
        end
        checks++; if (words_done_o !== '0) begin errors++; $display("FAIL len0_words: got %0d expected 0", words_done_o); end
    endtask

    task automatic test_write_stall();
        run_copy(32'h8000_2000, 32'h8000_3000, 16'd2, 5, 0);
        checks++; if (stall_seen !== 5) begin errors++; $display("FAIL stall_cycles: got %0d expected 5", stall_seen); end
        checks++; if (stable_bad !== 0) begin errors++; $display("FAIL stall_stability: got %0d unstable cycles expected 0", stable_bad); end
        checks++; if (done_at !== 14) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 14", done_at); end
        checks++; if (n_tx !== 4 || tx_wdata[1] !== mem_word(32'h8000_2000)) begin
            errors++; $display("FAIL stall_first_write: got tx=%0d wdata=%h expected 4 %h",
                               n_tx, tx_wdata[1], mem_word(32'h8000_2000));
        end
        checks++; if (words_done_o !== 16'd2) begin errors++; $display("FAIL stall_words: got %0d expected 2", words_done_o); end
    endtask

    task automatic test_reset_mid();
        int late_done;
        @(negedge clk);
        src_addr_i = 32'h8000_4000; dst_addr_i = 32'h8000_5000; len_i = 16'd4; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        checks++; if (obi.req !== 1'b1) begin errors++; $display("FAIL rstmid_req_before: got %b expected 1", obi.req); end
        obi.gnt = 1'b1;
        @(posedge clk); #1;
        obi.gnt = 1'b0;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        checks++; if (obi.req !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got req=%b busy=%b expected 0/0", obi.req, busy_o);
        end
        obi.rvalid = 1'b1; obi.rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        obi.rvalid = 1'b0;
        late_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done_o || busy_o || obi.req) late_done++;
            @(posedge clk); #1;
        end
        checks++; if (late_done !== 0) begin errors++; $display("FAIL rstmid_late_rvalid: got %0d active cycles expected 0", late_done); end
        checks++; if (words_done_o !== '0) begin errors++; $display("FAIL rstmid_words: got %0d expected 0", words_done_o); end
        run_copy(32'h8000_6000, 32'h8000_7000, 16'd1, 0, 0);
        checks++; if (done_at !== 5 || words_done_o !== 16'd1) begin
            errors++; $display("FAIL rstmid_restart: got done=%0d words=%0d expected 5/1", done_at, words_done_o);
        end
        checks++; if (n_tx !== 2 || tx_wdata[1] !== mem_word(32'h8000_6000)) begin
            errors++; $display("FAIL rstmid_restart_data: got tx=%0d wdata=%h expected 2 %h",
                               n_tx, tx_wdata[1], mem_word(32'h8000_6000));
        end
    endtask

    task automatic test_range();
        run_copy(32'h8000_0000, 32'h8000_BFFC, 16'd2, 0, 0);
`ifdef OBI_DMA_RANGE_CHECK_EN
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL range_err: got %b expected 1", err_o); end
        checks++; if (done_at !== 1) begin errors++; $display("FAIL range_done_cycle: got %0d expected 1", done_at); end
        checks++; if (any_req !== 1'b0 || n_tx !== 0) begin
            errors++; $display("FAIL range_traffic: got req_seen=%b tx=%0d expected 0/0", any_req, n_tx);
        end
`else
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL range_err: got %b expected 0", err_o); end
        checks++; if (done_at !== 9 || words_done_o !== 16'd2) begin
            errors++; $display("FAIL range_copy: got done=%0d words=%0d expected 9/2", done_at, words_done_o);
        end
        checks++; if (n_tx !== 4 || tx_addr[3] !== 32'h8000_C000) begin
            errors++; $display("FAIL range_last_write: got tx=%0d addr=%h expected 4 80010000-like c000", n_tx, tx_addr[3]);
        end
`endif
    endtask

    task automatic test_mid_start();
        run_copy(32'h8000_4000, 32'h8000_5000, 16'd2, 0, 3);
        checks++; if (done_at !== 9 || words_done_o !== 16'd2) begin
            errors++; $display("FAIL midstart_done: got done=%0d words=%0d expected 9/2", done_at, words_done_o);
        end
        checks++; if (n_tx !== 4 || tx_addr[2] !== 32'h8000_4004) begin
            errors++; $display("FAIL midstart_addr: got tx=%0d addr=%h expected 4 80004004", n_tx, tx_addr[2]);
        end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL midstart_err: got %b expected 0", err_o); end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_len_zero();
        test_write_stall();
        test_reset_mid();
        test_range();
        test_mid_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
